// File: rtl/pid_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pid_arb_pkg
//  Purpose  : Shared widths, FSM state type and duty saturation helper for
//             the dual-channel PID arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package pid_arb_pkg;

    localparam int ERR_W      = 13;  // signed error from the IR array
    localparam int INTEG_W    = 20;  // per-channel integrator width
    localparam int DUTY_W     = 12;  // PWM duty width
    localparam int HIST_DEPTH = 4;   // derivative history depth
    localparam int P_W        = 16;  // proportional term width
    localparam int SUM_W      = 17;  // width of P+I+D sum
    localparam int I_LSB      = 7;   // lowest integrator bit feeding the I term

    localparam logic [DUTY_W-1:0] DUTY_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        CALC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // Clamp a signed sum into the unsigned duty range [0, DUTY_MAX].
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [SUM_W-1:0] s);
        logic [DUTY_W-1:0] r;
        if (s[SUM_W-1]) begin
            r = '0;
        end else if (|s[SUM_W-2:DUTY_W]) begin
            r = DUTY_MAX;
        end else begin
            r = s[DUTY_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_math.sv
`default_nettype none
// ============================================================================
//  Module   : pid_math
//  Purpose  : Combinational P/I/D datapath. Produces the saturated duty and
//             the next (clamped) integrator value from latched operands.
//  Revision : 1.0  initial release
// ============================================================================
module pid_math
    import pid_arb_pkg::*;
#(
    parameter int P_COEFF = 3,
    parameter int I_NUM   = 2,
    parameter int D_COEFF = 0
) (
    input  logic signed [ERR_W-1:0]   err,
    input  logic        [INTEG_W-1:0] integ,
    input  logic signed [ERR_W-1:0]   hist_oldest,
    output logic        [DUTY_W-1:0]  duty,
    output logic        [INTEG_W-1:0] nxt_integ
);

    localparam logic signed [P_W-1:0]   P_K = 16'(P_COEFF);
    localparam logic        [P_W-1:0]   I_K = 16'(I_NUM);
    localparam logic signed [SUM_W-1:0] D_K = 17'(D_COEFF);

    logic signed [P_W-1:0]   err_p;
    logic signed [P_W-1:0]   p_prod;
    logic signed [P_W-1:0]   p_term;
    logic        [P_W-1:0]   i_prod;
    logic        [P_W-1:0]   i_term;
    logic signed [ERR_W:0]   diff;
    logic signed [SUM_W-1:0] diff_x;
    logic signed [SUM_W-1:0] d_term;
    logic        [SUM_W-1:0] sum;
    logic        [INTEG_W-1:0] integ_sum;

    // P/I/D terms, their sum, saturation and integrator update.
    always_comb begin
        err_p     = {{(P_W-ERR_W){err[ERR_W-1]}}, err};
        p_prod    = err_p * P_K;
        p_term    = p_prod >>> 2;

        // I uses the integrator before this update is applied.
        i_prod    = 16'(integ[I_LSB+DUTY_W-1:I_LSB]) * I_K;
        i_term    = i_prod >> 2;

        diff      = {err[ERR_W-1], err} - {hist_oldest[ERR_W-1], hist_oldest};
        diff_x    = {{(SUM_W-ERR_W-1){diff[ERR_W]}}, diff};
        d_term    = diff_x * D_K;

        sum       = {p_term[P_W-1], p_term} + {1'b0, i_term} + d_term;
        duty      = sat_duty(sum);

        // Bit 19 set means the running sum went negative or past 2^19:
        // either way the integrator restarts from zero.
        integ_sum = integ + {{(INTEG_W-ERR_W){err[ERR_W-1]}}, err};
        nxt_integ = integ_sum[INTEG_W-1] ? '0 : integ_sum;
    end

endmodule
`default_nettype wire

// File: rtl/pid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pid_arbiter
//  Purpose  : Round-robin arbiter in front of one shared PID engine serving
//             the left (ch0) and right (ch1) motor duty channels. Holds the
//             per-channel integrator and derivative history.
//  Revision : 1.0  initial release
// ============================================================================
module pid_arbiter
    import pid_arb_pkg::*;
#(
    parameter int P_COEFF = 3,
    parameter int I_NUM   = 2,
    parameter int D_COEFF = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic        [1:0]        req,
    input  logic signed [ERR_W-1:0]  err0,
    input  logic signed [ERR_W-1:0]  err1,
    input  logic        [1:0]        clr,
    output logic        [DUTY_W-1:0] duty0,
    output logic        [DUTY_W-1:0] duty1,
    output logic        [1:0]        ack,
    output logic                     busy
);

    // Sequencer and arbitration.
    state_e state_q, state_d;
    logic   grant_q, grant_d;   // channel currently being served
    logic   last_q,  last_d;    // channel granted most recently

    // Operand and result registers of the shared datapath.
    logic [ERR_W-1:0]   op_err_q,   op_err_d;
    logic [INTEG_W-1:0] op_integ_q, op_integ_d;
    logic [ERR_W-1:0]   op_hist_q,  op_hist_d;
    logic [DUTY_W-1:0]  res_duty_q, res_duty_d;
    logic [INTEG_W-1:0] res_integ_q, res_integ_d;

    // Per-channel state and outputs.
    logic [INTEG_W-1:0] integ_q [0:1];
    logic [INTEG_W-1:0] integ_d [0:1];
    logic [ERR_W-1:0]   hist_q  [0:1][0:HIST_DEPTH-1];
    logic [ERR_W-1:0]   hist_d  [0:1][0:HIST_DEPTH-1];
    logic [DUTY_W-1:0]  duty_q  [0:1];
    logic [DUTY_W-1:0]  duty_d  [0:1];
    logic [1:0]         ack_q,  ack_d;

    logic [DUTY_W-1:0]  m_duty;
    logic [INTEG_W-1:0] m_nxt_integ;

    pid_math #(
        .P_COEFF (P_COEFF),
        .I_NUM   (I_NUM),
        .D_COEFF (D_COEFF)
    ) u_math (
        .err         (op_err_q),
        .integ       (op_integ_q),
        .hist_oldest (op_hist_q),
        .duty        (m_duty),
        .nxt_integ   (m_nxt_integ)
    );

    // Next-state logic for the sequencer, datapath registers and channel state.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        op_err_d    = op_err_q;
        op_integ_d  = op_integ_q;
        op_hist_d   = op_hist_q;
        res_duty_d  = res_duty_q;
        res_integ_d = res_integ_q;
        integ_d     = integ_q;
        hist_d      = hist_q;
        duty_d      = duty_q;
        ack_d       = 2'b00;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    // On contention, serve the channel not served last.
                    grant_d = (req == 2'b11) ? ~last_q : req[1];
                    last_d  = grant_d;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                op_err_d   = grant_q ? err1 : err0;
                op_integ_d = integ_q[grant_q];
                op_hist_d  = hist_q[grant_q][HIST_DEPTH-1];
                state_d    = CALC;
            end
            CALC: begin
                res_duty_d  = m_duty;
                res_integ_d = m_nxt_integ;
                state_d     = WRITE;
            end
            WRITE: begin
                duty_d[grant_q]   = res_duty_q;
                ack_d[grant_q]    = 1'b1;
                integ_d[grant_q]  = res_integ_q;
                for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                    hist_d[grant_q][k] = hist_q[grant_q][k-1];
                end
                hist_d[grant_q][0] = op_err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear overrides any state write-back, but not the duty/ack.
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) begin
                integ_d[c] = '0;
                for (int k = 0; k < HIST_DEPTH; k++) begin
                    hist_d[c][k] = '0;
                end
            end
        end
    end

    // State registers with asynchronous reset; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            op_err_q    <= '0;
            op_integ_q  <= '0;
            op_hist_q   <= '0;
            res_duty_q  <= '0;
            res_integ_q <= '0;
            ack_q       <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                integ_q[c] <= '0;
                duty_q[c]  <= '0;
                for (int k = 0; k < HIST_DEPTH; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            op_err_q    <= op_err_d;
            op_integ_q  <= op_integ_d;
            op_hist_q   <= op_hist_d;
            res_duty_q  <= res_duty_d;
            res_integ_q <= res_integ_d;
            ack_q       <= ack_d;
            integ_q     <= integ_d;
            hist_q      <= hist_d;
            duty_q      <= duty_d;
        end
    end

    assign duty0 = duty_q[0];
    assign duty1 = duty_q[1];
    assign ack   = ack_q;
    assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire
